// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a three-digit common-anode
// seven-segment display. It scans a 21-bit active-low segment word onto one
// shared segment bus and three active-low digit enables. All-off guard
// intervals separate the digits. New words are double-buffered and take effect
// only at frame boundaries.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zeros in the
// hundreds and tens digits when a word is committed.
module seg_scan_driver #(
  parameter int CLK_DIV      = 50000,
  parameter int GUARD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [20:0] segments_in,
  output logic [6:0]  seg_out,
  output logic [2:0]  an,
  output logic        pending,
  output logic        frame_done
);

  localparam int CNT_MAX = (CLK_DIV > GUARD_CYCLES) ? CLK_DIV : GUARD_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'((GUARD_CYCLES > 0) ? GUARD_CYCLES - 1 : 0);
  localparam logic [6:0]  SEG_BLANK  = 7'h7F;
  localparam logic [6:0]  SEG_ZERO   = 7'b0000001;
  localparam logic [20:0] WORD_BLANK = 21'h1FFFFF;

  typedef enum logic {SHOW, GUARD} phase_t;

  phase_t            phase, phase_nxt;
  logic [1:0]        dig, dig_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              wrap;
  logic [20:0]       pend_r, disp_r, disp_nxt;
  logic              pend_v;
  logic              commit;

  // Transform applied to a word as it moves from pending to display.
  function automatic logic [20:0] commit_word(input logic [20:0] w);
    logic [20:0] r;
    r = w;
`ifdef LEADING_ZERO_BLANK_EN
    if (w[20:14] == SEG_ZERO) begin
      r[20:14] = SEG_BLANK;
      if (w[13:7] == SEG_ZERO) r[13:7] = SEG_BLANK;
    end
`endif
    return r;
  endfunction

  function automatic logic [6:0] digit_slice(input logic [20:0] w, input logic [1:0] d);
    case (d)
      2'd0:    return w[6:0];
      2'd1:    return w[13:7];
      default: return w[20:14];
    endcase
  endfunction

  function automatic logic [2:0] anode_sel(input logic [1:0] d);
    case (d)
      2'd0:    return 3'b110;
      2'd1:    return 3'b101;
      default: return 3'b011;
    endcase
  endfunction

  function automatic logic [1:0] next_digit(input logic [1:0] d);
    return (d == 2'd2) ? 2'd0 : d + 2'd1;
  endfunction

  // Phase, digit and counter state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= SHOW;
      dig   <= 2'd0;
      cnt   <= '0;
    end else begin
      phase <= phase_nxt;
      dig   <= dig_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic for the SHOW/GUARD scan sequence.
  always_comb begin
    phase_nxt = phase;
    dig_nxt   = dig;
    cnt_nxt   = cnt + CNT_W'(1);
    wrap      = 1'b0;
    unique case (phase)
      SHOW: begin
        if (cnt == SHOW_LAST) begin
          cnt_nxt = '0;
          if (GUARD_CYCLES == 0) begin
            dig_nxt = next_digit(dig);
            wrap    = (dig == 2'd2);
          end else begin
            phase_nxt = GUARD;
          end
        end
      end
      GUARD: begin
        if (cnt == GUARD_LAST) begin
          cnt_nxt   = '0;
          phase_nxt = SHOW;
          dig_nxt   = next_digit(dig);
          wrap      = (dig == 2'd2);
        end
      end
    endcase
  end

  // The commit edge is the one ending the frame_done cycle.
  assign commit   = frame_done & pend_v;
  assign disp_nxt = commit ? commit_word(pend_r) : disp_r;

  // Pending/display word buffers; a load on the commit edge stays pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_r <= WORD_BLANK;
      pend_v <= 1'b0;
      disp_r <= WORD_BLANK;
    end else begin
      if (load) begin
        pend_r <= segments_in;
        pend_v <= 1'b1;
      end else if (commit) begin
        pend_v <= 1'b0;
      end
      disp_r <= disp_nxt;
    end
  end

  // Registered outputs. Segments use disp_nxt so the first lit cycle of a new
  // frame already shows the freshly committed word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_out    <= SEG_BLANK;
      an         <= 3'b111;
      frame_done <= 1'b0;
    end else begin
      frame_done <= wrap;
      if (phase == SHOW) begin
        an      <= anode_sel(dig);
        seg_out <= digit_slice(disp_nxt, dig);
      end else begin
        an      <= 3'b111;
        seg_out <= SEG_BLANK;
      end
    end
  end

  assign pending = pend_v;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver. Expected lit-digit presentations are
// queued by the stimulus process and consumed by a monitor on every lit cycle.
`timescale 1ns/1ps
module tb_seg_scan_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, load;
  logic [20:0] seg_in;
  logic [6:0]  seg_out;
  logic [2:0]  an;
  logic        pending, frame_done;

  logic        rst_b;
  logic [6:0]  seg_out_b;
  logic [2:0]  an_b;
  logic        pending_b, frame_done_b;

  seg_scan_driver #(.CLK_DIV(4), .GUARD_CYCLES(1)) dut (
    .clk(clk), .rst(rst), .load(load), .segments_in(seg_in),
    .seg_out(seg_out), .an(an), .pending(pending), .frame_done(frame_done)
  );

  seg_scan_driver #(.CLK_DIV(2), .GUARD_CYCLES(0)) dut_ng (
    .clk(clk), .rst(rst_b), .load(1'b0), .segments_in(21'h1FFFFF),
    .seg_out(seg_out_b), .an(an_b), .pending(pending_b), .frame_done(frame_done_b)
  );

  localparam logic [6:0] BL = 7'h7F;
  localparam logic [6:0] D0 = 7'b0000001;
  localparam logic [6:0] D1 = 7'b1001111;
  localparam logic [6:0] D2 = 7'b0010010;
  localparam logic [6:0] D3 = 7'b0000110;
  localparam logic [6:0] D4 = 7'b1001100;
  localparam logic [6:0] D5 = 7'b0100100;
  localparam logic [6:0] D7 = 7'b0001111;

  localparam logic [20:0] W_BLANK = 21'h1FFFFF;
  localparam logic [20:0] W123 = {D1, D2, D3};
  localparam logic [20:0] W007 = {D0, D0, D7};
  localparam logic [20:0] W045 = {D0, D4, D5};
  localparam logic [20:0] W100 = {D1, D0, D0};
`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [20:0] E007 = {BL, BL, D7};
  localparam logic [20:0] E045 = {BL, D4, D5};
`else
  localparam logic [20:0] E007 = W007;
  localparam logic [20:0] E045 = W045;
`endif

  typedef struct packed {
    logic [2:0] an;
    logic [6:0] seg;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Queue one full frame (4 lit cycles per digit) of expected presentations.
  task automatic push_frame(input logic [20:0] w);
    logic [2:0] a [3];
    logic [6:0] s [3];
    a[0] = 3'b110; a[1] = 3'b101; a[2] = 3'b011;
    s[0] = w[6:0]; s[1] = w[13:7]; s[2] = w[20:14];
    for (int d = 0; d < 3; d++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{an: a[d], seg: s[d]});
  endtask

  task automatic wait_fd(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (frame_done !== 1'b1 && n < 100);
    check("fd_timeout", 32'(frame_done), 32'd1);
  endtask

  task automatic pulse_load(input logic [20:0] w);
    load   = 1'b1;
    seg_in = w;
    @(negedge clk);
    load   = 1'b0;
  endtask

  // Monitor: legal anode pattern every cycle; compare each lit cycle with the queue.
  always @(negedge clk) begin
    check("an_onehot", 32'(an inside {3'b111, 3'b110, 3'b101, 3'b011}), 32'd1);
    if (an !== 3'b111 && exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("scan_an", 32'(an), 32'(mon_e.an));
      check("scan_seg", 32'(seg_out), 32'(mon_e.seg));
    end
  end

  initial begin
    int n;
    logic [2:0] tbl [6];
    bit found;
    tbl[0] = 3'b110; tbl[1] = 3'b110; tbl[2] = 3'b101;
    tbl[3] = 3'b101; tbl[4] = 3'b011; tbl[5] = 3'b011;

    rst = 1'b1; rst_b = 1'b1; load = 1'b0; seg_in = '0;
    repeat (3) @(negedge clk);
    check("rst_an", 32'(an), 32'b111);
    check("rst_seg", 32'(seg_out), 32'h7F);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_fd", 32'(frame_done), 32'd0);

    // Reset release and blank scan.
    push_frame(W_BLANK);
    rst = 1'b0;
    @(negedge clk);
    check("first_an", 32'(an), 32'b110);
    check("first_seg", 32'(seg_out), 32'h7F);
    wait_fd(n);
    push_frame(W_BLANK);
    wait_fd(n);
    check("fd_period", 32'(n), 32'd15);
    push_frame(W_BLANK);

    // Mid-frame load commits at the next boundary.
    repeat (5) @(negedge clk);
    check("pend_idle", 32'(pending), 32'd0);
    pulse_load(W123);
    check("pend_rise", 32'(pending), 32'd1);
    wait_fd(n);
    check("pend_hold", 32'(pending), 32'd1);
    push_frame(W123);
    @(negedge clk);
    check("pend_fall", 32'(pending), 32'd0);

    // Load on the boundary cycle: old word commits, new one stays pending.
    repeat (5) @(negedge clk);
    pulse_load(W007);
    wait_fd(n);
    load = 1'b1; seg_in = W045;
    push_frame(E007);
    @(negedge clk);
    load = 1'b0;
    check("pend_bound_load", 32'(pending), 32'd1);
    wait_fd(n);
    check("pend_hold2", 32'(pending), 32'd1);
    push_frame(E045);
    @(negedge clk);
    check("pend_fall2", 32'(pending), 32'd0);

    // Hundreds digit nonzero: nothing blanked.
    repeat (5) @(negedge clk);
    pulse_load(W100);
    wait_fd(n);
    push_frame(W100);
    wait_fd(n);

    // Async reset during the tens digit with a pending word.
    repeat (3) @(negedge clk);
    pulse_load(W123);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (an === 3'b101) found = 1'b1;
    end
    check("tens_found", 32'(found), 32'd1);
    check("pend_pre_rst", 32'(pending), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_an", 32'(an), 32'b111);
    check("async_seg", 32'(seg_out), 32'h7F);
    check("async_pending", 32'(pending), 32'd0);
    check("async_fd", 32'(frame_done), 32'd0);
    @(negedge clk);
    push_frame(W_BLANK);
    rst = 1'b0;
    wait_fd(n);
    push_frame(W_BLANK);
    wait_fd(n);
    check("queue_drain", 32'(exp_q.size()), 32'd0);

    // No-guard variant.
    @(negedge clk);
    rst_b = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      check("ng_an", 32'(an_b), 32'(tbl[(k - 1) % 6]));
      check("ng_fd", 32'(frame_done_b), 32'((k % 6) == 0));
      check("ng_seg", 32'(seg_out_b), 32'h7F);
    end
    check("ng_pending", 32'(pending_b), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
# seg_scan_driver

Time-multiplexed driver for the three-digit common-anode seven-segment display. Consumes the 21-bit packed segment word from the binary-to-BCD/segment-decode stage and scans it onto one shared active-low segment bus plus three active-low digit enables. Anode-off guard intervals between digits prevent ghosting. A shadow register commits new words only at frame boundaries, so a digit never tears mid-frame.

## Interface

Parameters:

- `CLK_DIV`, default 50000: clk cycles each digit is lit (SHOW phase); legal range ≥ 2.
- `GUARD_CYCLES`, default 16: clk cycles of all-anodes-off after each digit; 0 skips GUARD entirely.

Ports:

- `clk`  in  1: single clock; all flops rise-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `load`  in  1: 1-cycle strobe; captures `segments_in` into the pending register.
- `segments_in`  in  21: packed patterns, active-low.
  - `[6:0]` units, `[13:7]` tens, `[20:14]` hundreds.
  - Per digit, bit 6 = a … bit 0 = g.
  - `7'b1111111` = blank.
- `seg_out`  out  7: shared segment bus, active-low, same bit order.
- `an`  out  3: digit enables, active-low; `an[0]` units, `an[1]` tens, `an[2]` hundreds.
- `pending`  out  1: a captured word awaits commit.
- `frame_done`  out  1: 1-cycle pulse on each frame boundary.

## Operation

- Registers:
  - `pend_r[20:0]`, `pend_v`, `disp_r[20:0]`.
  - Digit index `dig` (0..2).
  - Phase FSM: SHOW/GUARD.
  - Cycle counter `cnt`, width clog2(max(CLK_DIV, GUARD_CYCLES)).
- Reset values:
  - `disp_r` = `pend_r` = 21'h1FFFFF.
  - `pend_v` = 0, `dig` = 0, phase = SHOW, `cnt` = 0.
  - `seg_out` = 7'h7F, `an` = 3'b111, `pending` = 0, `frame_done` = 0.
- SHOW:
  - `an` has only bit `dig` low; `seg_out` = `disp_r` slice for `dig`.
  - `cnt` counts 0..CLK_DIV-1.
  - At CLK_DIV-1: `cnt` ← 0 and phase ← GUARD.
  - If GUARD_CYCLES = 0, go instead directly to SHOW with the next digit.
- GUARD:
  - `an` = 3'b111, `seg_out` = 7'h7F.
  - `cnt` counts 0..GUARD_CYCLES-1.
  - Then `cnt` ← 0, `dig` ← `dig`+1 (2 wraps to 0), phase ← SHOW.
- Frame boundary: the cycle on which `dig` wraps 2→0.
  - `frame_done` = 1 for exactly that cycle.
  - If `pend_v`: `disp_r` ← `pend_r` and `pend_v` ← 0.
- Load:
  - `load` = 1 sets `pend_r` ← `segments_in` and `pend_v` ← 1 on that edge.
  - Back-to-back loads overwrite `pend_r`; last word wins.
- Load on the boundary cycle:
  - The old `pend_r` commits to `disp_r`.
  - The new word goes to `pend_r` and `pend_v` stays 1, so it commits at the next boundary.
- Segment values are passed through unchecked; any 7-bit pattern is displayed as given.

## Timing

- `seg_out`, `an`, `pending` and `frame_done` are driven from flops, so there are no combinational paths from inputs.
- Frame length = 3·(CLK_DIV + GUARD_CYCLES) cycles.
- First edge after `rst` deasserts:
  - `an` = 3'b110.
  - `seg_out` = units slice of `disp_r`, which is blank until the first commit.
- `pending` rises on the edge after `load`, and falls on the boundary edge, unless a load coincides with it.
- Load-to-display latency: up to one full frame plus one cycle. A word is never visible mid-frame.
- `rst` asserted mid-frame:
  - Immediate return to all reset values.
  - `an` = 3'b111 within the same cycle, asynchronously.
  - Pending data is discarded.
- `an` never has more than one bit low. Going from one lit digit to the next always passes through `an` = 3'b111 when GUARD_CYCLES > 0.

## Configuration

- `LEADING_ZERO_BLANK_EN` defined:
  - At commit, the hundreds slice is replaced by 7'h7F if it equals 7'b0000001.
  - The tens slice is replaced likewise only if hundreds was blanked and tens equals 7'b0000001.
  - Units are never blanked.
  - Example: a word encoding 007 displays as "  7".
- Undefined: `disp_r` ← `pend_r` verbatim, so 007 displays as "007".

## Test plan

- **Reset and scan:** CLK_DIV=4, GUARD_CYCLES=1, release `rst`, no load.
  - `an` sequence 110×4, 111×1, 101×4, 111, 011×4, 111, repeat.
  - `seg_out` = 7'h7F throughout; `frame_done` every 15 cycles.
- **Commit at boundary:** load the word for 123 (hundreds 7'b1001111, tens 7'b0010010, units 7'b0000110) mid-frame.
  - `pending` = 1 until the boundary.
  - The next frame shows 0000110 under `an` 110, 0010010 under 101, and 1001111 under 011.
- **Load on boundary cycle:** load 123 mid-frame, then load 45 exactly on the `frame_done` cycle.
  - The next frame shows 123.
  - `pending` stays 1, and the frame after shows 45.
- **Async reset mid-frame:** assert `rst` during SHOW of the tens digit with `pend_v` = 1.
  - `an` = 111 and `seg_out` = 7F without waiting for a clock edge.
  - After release, scanning restarts at units showing blank.
- **Zero blanking:** load 007.
  - With `LEADING_ZERO_BLANK_EN`: hundreds and tens show 7'h7F, units shows 0001111.
  - Without it: hundreds and tens show 0000001.
  - Load 100: with the macro, nothing is blanked.
- **No-guard variant:** GUARD_CYCLES=0, CLK_DIV=2.
  - `an` sequence 110,110,101,101,011,011, repeating.
  - No all-off cycles; `frame_done` every 6 cycles.
